// File: rtl/seq_scrittura_lettura_param.sv
// Write-then-read address sequencer for the on-chip buffer RAM: len writes, then READ_PASSES read sweeps.
// we is combinational from wr_valid; other outputs are registered; rd_ready low holds the read address stable.
module seq_scrittura_lettura_param #(
    parameter int ADDR_W      = 9,
    parameter int DEPTH       = 512,
    parameter int READ_PASSES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   write_len,
    input  logic              abort,
    input  logic              wr_valid,
    input  logic              rd_ready,
    output logic              we,
    output logic [ADDR_W-1:0] indirizzo_write,
    output logic [ADDR_W-1:0] indirizzo_read,
    output logic              rd_valid,
    output logic              busy,
    output logic              done,
    output logic [1:0]        state
);

    localparam int                PASS_W    = (READ_PASSES > 1) ? $clog2(READ_PASSES) : 1;
    localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W + 1)'(DEPTH);
    localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(READ_PASSES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_WRITE = 2'b01,
        S_READ  = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W:0]     len_q, len_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic [PASS_W-1:0]   pass_q, pass_d;
    logic                rd_valid_q, rd_valid_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [ADDR_W:0]     len_m1;
    logic                wr_last, rd_last, rd_fire;

    assign len_m1  = len_q - {{ADDR_W{1'b0}}, 1'b1};
    assign wr_last = ({1'b0, wr_addr_q} == len_m1);
    assign rd_last = ({1'b0, rd_addr_q} == len_m1);
    assign rd_fire = rd_valid_q & rd_ready;

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        wr_addr_d = wr_addr_q;
        rd_addr_d = rd_addr_q;
        pass_d    = pass_q;
        case (state_q)
            S_IDLE: begin
                if (start && (write_len != '0)) begin
                    len_d     = (write_len > DEPTH_L) ? DEPTH_L : write_len;
                    wr_addr_d = '0;
                    state_d   = S_WRITE;
                end
            end
            S_WRITE: begin
                if (wr_valid) begin
                    if (wr_last) begin
                        wr_addr_d = '0;
                        rd_addr_d = '0;
                        pass_d    = '0;
                        state_d   = S_READ;
                    end else begin
                        wr_addr_d = wr_addr_q + ADDR_W'(1);
                    end
                end
            end
            S_READ: begin
                if (rd_fire) begin
                    if (rd_last) begin
                        rd_addr_d = '0;
                        if (pass_q == LAST_PASS) state_d = S_DONE;
                        else                     pass_d  = pass_q + PASS_W'(1);
                    end else begin
                        rd_addr_d = rd_addr_q + ADDR_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Abort cancels the job outright: no DONE pulse, counters back to zero.
        if (abort && (state_q != S_IDLE)) begin
            state_d   = S_IDLE;
            wr_addr_d = '0;
            rd_addr_d = '0;
            pass_d    = '0;
        end
        busy_d     = (state_d != S_IDLE);
        rd_valid_d = (state_d == S_READ);
        done_d     = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            wr_addr_q  <= '0;
            rd_addr_q  <= '0;
            pass_q     <= '0;
            rd_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            wr_addr_q  <= wr_addr_d;
            rd_addr_q  <= rd_addr_d;
            pass_q     <= pass_d;
            rd_valid_q <= rd_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign we              = (state_q == S_WRITE) & wr_valid;
    assign indirizzo_write = wr_addr_q;
    assign indirizzo_read  = rd_addr_q;
    assign rd_valid        = rd_valid_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign state           = state_q;

endmodule

// File: tb/tb_seq_scrittura_lettura_param.sv
// Two instances (1 and 3 read passes) share stimulus; a scoreboard of expected
// state/write/read/done events per job is drained by a negedge monitor.
module tb_seq_scrittura_lettura_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, start, abort, wr_valid, rd_ready;
    logic [9:0] write_len;

    logic       we1, rv1, busy1, done1, we3, rv3, busy3, done3;
    logic [8:0] wa1, ra1, wa3, ra3;
    logic [1:0] st1, st3;

    seq_scrittura_lettura_param #(.ADDR_W(9), .DEPTH(512), .READ_PASSES(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start), .write_len(write_len), .abort(abort),
        .wr_valid(wr_valid), .rd_ready(rd_ready), .we(we1), .indirizzo_write(wa1),
        .indirizzo_read(ra1), .rd_valid(rv1), .busy(busy1), .done(done1), .state(st1));

    seq_scrittura_lettura_param #(.ADDR_W(9), .DEPTH(512), .READ_PASSES(3)) u_dut3 (
        .clk(clk), .reset(reset), .start(start), .write_len(write_len), .abort(abort),
        .wr_valid(wr_valid), .rd_ready(rd_ready), .we(we3), .indirizzo_write(wa3),
        .indirizzo_read(ra3), .rd_valid(rv3), .busy(busy3), .done(done3), .state(st3));

    int errors = 0;
    int checks = 0;
    int exp1[$];
    int exp3[$];
    bit mon_en = 1'b0;
    int p_wr = 100, p_rd = 100;
    bit toggle_rd = 1'b0, rnd_start = 1'b0;
    int prev_st[4], prev_ra[4];
    bit prev_hold[4];

    localparam int EV_W = 'h10000, EV_R = 'h20000, EV_D = 'h30000, EV_S = 'h40000;

    function automatic void chk(string name, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endfunction

    function automatic void push_ev(int idx, int ev);
        if (idx == 1) exp1.push_back(ev);
        else          exp3.push_back(ev);
    endfunction

    function automatic void chk_ev(int idx, int ev);
        int e;
        checks++;
        if ((idx == 1 && exp1.size() == 0) || (idx == 3 && exp3.size() == 0)) begin
            errors++;
            $display("FAIL unexpected_event dut%0d: got %0h expected none", idx, ev);
            return;
        end
        e = (idx == 1) ? exp1.pop_front() : exp3.pop_front();
        if (e != ev) begin
            errors++;
            $display("FAIL event dut%0d: got %0h expected %0h", idx, ev, e);
        end
    endfunction

    // Reference: a job of n words writes 0..L-1, reads 0..L-1 once per pass, then pulses done.
    function automatic void push_job(int n);
        int l;
        l = (n > 512) ? 512 : n;
        for (int idx = 1; idx <= 3; idx += 2) begin
            push_ev(idx, EV_S | 1);
            for (int a = 0; a < l; a++) push_ev(idx, EV_W | a);
            push_ev(idx, EV_S | 2);
            for (int p = 0; p < idx; p++)
                for (int a = 0; a < l; a++) push_ev(idx, EV_R | a);
            push_ev(idx, EV_S | 3);
            push_ev(idx, EV_D);
            push_ev(idx, EV_S | 0);
        end
    endfunction

    function automatic void mon(int idx, logic [1:0] st, logic w, logic [8:0] wa,
                                logic [8:0] ra, logic rv, logic b, logic d);
        if (int'(st) != prev_st[idx]) chk_ev(idx, EV_S | int'(st));
        if (w) chk_ev(idx, EV_W | int'(wa));
        if (rv && rd_ready) chk_ev(idx, EV_R | int'(ra));
        if (d) chk_ev(idx, EV_D);
        chk($sformatf("flags_dut%0d", idx), int'({b, rv, w, d}),
            int'({st != 2'd0, st == 2'd2, (st == 2'd1) && wr_valid, st == 2'd3}));
        if (prev_hold[idx] && rv) chk($sformatf("rd_hold_dut%0d", idx), int'(ra), prev_ra[idx]);
        prev_st[idx]   = int'(st);
        prev_hold[idx] = rv && !rd_ready;
        prev_ra[idx]   = int'(ra);
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            mon(1, st1, we1, wa1, ra1, rv1, busy1, done1);
            mon(3, st3, we3, wa3, ra3, rv3, busy3, done3);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain_check(string name);
        @(negedge clk);
        #1;
        chk({name, "_q1_left"}, exp1.size(), 0);
        chk({name, "_q3_left"}, exp3.size(), 0);
    endtask

    task automatic run_job(string name, int n);
        bit fin;
        push_job(n);
        write_len = 10'(n);
        start = 1'b1;
        tick();
        start = 1'b0;
        fin = 1'b0;
        for (int c = 0; c < 8000; c++) begin
            if (st1 == 2'd0 && st3 == 2'd0) begin
                fin = 1'b1;
                break;
            end
            wr_valid = ($urandom_range(99) < p_wr);
            rd_ready = toggle_rd ? !rd_ready : ($urandom_range(99) < p_rd);
            if (rnd_start && st1 != 2'd0 && st3 != 2'd0) begin
                start     = 1'($urandom_range(1));
                write_len = 10'($urandom_range(1023));
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        chk({name, "_finished"}, int'(fin), 1);
        drain_check(name);
    endtask

    initial begin
        reset = 1'b0; start = 1'b1; abort = 1'b0; wr_valid = 1'b1; rd_ready = 1'b1;
        write_len = 10'd4;
        for (int i = 0; i < 4; i++) begin
            prev_st[i] = 0; prev_ra[i] = 0; prev_hold[i] = 1'b0;
        end
        tick();
        mon_en = 1'b1;
        // Reset dominates start
        for (int i = 0; i < 3; i++) begin
            chk("reset_outputs_dut1", int'({st1, we1, wa1, ra1, rv1, busy1, done1}), 0);
            chk("reset_outputs_dut3", int'({st3, we3, wa3, ra3, rv3, busy3, done3}), 0);
            tick();
        end
        reset = 1'b1;
        start = 1'b0;
        tick();

        run_job("len4", 4);
        run_job("len600", 600);
        toggle_rd = 1'b1;
        run_job("len2_toggle", 2);
        toggle_rd = 1'b0;

        // Abort while the write address is 5
        wr_valid = 1'b1;
        rd_ready = 1'b1;
        for (int idx = 1; idx <= 3; idx += 2) begin
            push_ev(idx, EV_S | 1);
            for (int a = 0; a < 5; a++) push_ev(idx, EV_W | a);
            push_ev(idx, EV_S | 0);
        end
        write_len = 10'd10;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (wa1 == 9'd5) break;
            tick();
        end
        chk("abort_at_addr5", int'(wa1), 5);
        wr_valid = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_state", int'({st1, st3, we1, we3, done1, done3}), 0);
        drain_check("abort");
        run_job("after_abort", 3);

        // Zero length is ignored
        write_len = 10'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("len0_idle", int'({st1, st3}), 0);

        // Reset in the middle of READ with the consumer stalled
        for (int idx = 1; idx <= 3; idx += 2) begin
            push_ev(idx, EV_S | 1);
            for (int a = 0; a < 3; a++) push_ev(idx, EV_W | a);
            push_ev(idx, EV_S | 2);
            push_ev(idx, EV_S | 0);
        end
        wr_valid = 1'b1;
        rd_ready = 1'b0;
        write_len = 10'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (st1 == 2'd2) break;
            tick();
        end
        chk("reached_read", int'(st1), 2);
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("midread_reset_dut1", int'({st1, we1, wa1, ra1, rv1, busy1, done1}), 0);
        chk("midread_reset_dut3", int'({st3, we3, wa3, ra3, rv3, busy3, done3}), 0);
        reset = 1'b1;
        drain_check("midread_reset");

        // Random jobs with stalls on both sides and spurious start while busy
        p_wr = 60;
        p_rd = 50;
        rnd_start = 1'b1;
        for (int j = 0; j < 15; j++) begin
            int n;
            n = ($urandom_range(9) == 0) ? int'($urandom_range(700, 513)) : int'($urandom_range(24, 1));
            run_job($sformatf("rand%0d", j), n);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
